key_conditioner: RTL

- Parametrised N-channel push-button/switch conditioner for the FPGA fabric. Successor to the fixed 2-key debounce feeding the HPS STM event bus and LEDs.
- Per channel it provides:
  - a synchroniser;
  - selectable input polarity;
  - a debounce filter;
  - one-cycle press and release pulses;
  - optional long-press detection (compile-time).
- Sits between board KEY/SW pins and soc_system / user logic. All outputs are active-high "pressed".

---
 rtl/key_cond_pkg.sv | 25 ++
 rtl/key_cond_channel.sv | 136 +++++++++++++
 rtl/key_conditioner.sv | 71 +++++++
 3 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key conditioner.
// Long-press logic is only built with KEY_COND_LONGPRESS_EN defined.
package key_cond_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StHeld
    } long_state_e;

    // Raw pin level of a released key.
    function automatic logic sync_rst_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_cond_channel.sv
// One key channel: synchroniser, debounce filter, press/release pulses, long-press FSM.
// The long-press FSM is built only when KEY_COND_LONGPRESS_EN is defined.
module key_cond_channel
    import key_cond_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TIMEOUT       = 50000,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned LONG_TICKS    = 1000,
    parameter int unsigned LONG_WIDTH    = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_pulse_o,
    output logic long_held_o
);

    // The chain carries the raw pin, so it resets to the released pin level;
    // XOR with ACTIVE_LOW at the tap gives the normalised "pressed" level.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     stable_q, stable_d;
    logic                     press_q, release_q;
    logic                     accept, rise, fall;

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
            stable_d = s;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign rise = accept & s;
    assign fall = accept & ~s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= {SYNC_STAGES{sync_rst_level(ACTIVE_LOW)}};
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], data_i};
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef KEY_COND_LONGPRESS_EN
    long_state_e           state_q, state_d;
    logic [LONG_WIDTH-1:0] ltc_q, ltc_d;
    logic                  long_pulse_q, long_pulse_d;

    // Arms on the same edge that flips stable, so press_pulse coincides with ARMED.
    always_comb begin
        state_d      = state_q;
        ltc_d        = ltc_q;
        long_pulse_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StArmed;
                    ltc_d   = '0;
                end
            end
            StArmed: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (tick_i) begin
                    if (ltc_q == LONG_WIDTH'(LONG_TICKS - 1)) begin
                        state_d      = StHeld;
                        long_pulse_d = 1'b1;
                    end else begin
                        ltc_d = ltc_q + LONG_WIDTH'(1);
                    end
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ltc_q        <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ltc_q        <= ltc_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign long_pulse_o = long_pulse_q;
    assign long_held_o  = (state_q == StHeld);
`else
    logic                  unused_tick;
    logic [LONG_WIDTH-1:0] unused_long_ticks;

    assign unused_tick       = tick_i;
    assign unused_long_ticks = LONG_WIDTH'(LONG_TICKS);
    assign long_pulse_o      = 1'b0;
    assign long_held_o       = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// N-channel key conditioner top: per-channel debounce plus a shared long-press tick prescaler.
// Long-press detection is built only when KEY_COND_LONGPRESS_EN is defined.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TIMEOUT       = 50000,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned LONG_TICKS    = 1000,
    parameter int unsigned LONG_WIDTH    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] long_held
);

    logic tick;

`ifdef KEY_COND_LONGPRESS_EN
    localparam int unsigned TickWidth = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    logic [TickWidth-1:0] div_q;

    assign tick = (div_q == TickWidth'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + TickWidth'(1);
        end
    end
`else
    logic [31:0] unused_tick_div;

    assign unused_tick_div = TICK_DIV;
    assign tick            = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_cond_channel #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .SYNC_STAGES   (SYNC_STAGES),
            .TIMEOUT       (TIMEOUT),
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
            .LONG_TICKS    (LONG_TICKS),
            .LONG_WIDTH    (LONG_WIDTH)
        ) u_chan (
            .clk_i        (clk),
            .rst_i        (rst),
            .data_i       (data_in[i]),
            .tick_i       (tick),
            .level_o      (data_out[i]),
            .press_o      (press_pulse[i]),
            .release_o    (release_pulse[i]),
            .long_pulse_o (long_pulse[i]),
            .long_held_o  (long_held[i])
        );
    end

endmodule
